// File: rtl/cellrv32_cpu_cp_arbiter_pkg.sv
// Shared co-processor arbiter types: FSM state encoding, unit index map and timeout default.
package cellrv32_package;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    CAPTURE = 2'd2
  } cp_arb_state_t;

  localparam int CP_SEL_SHIFT    = 0;
  localparam int CP_SEL_MULDIV   = 1;
  localparam int CP_SEL_BITMANIP = 2;
  localparam int CP_SEL_FPU      = 3;
  localparam int CP_SEL_COND     = 4;

  localparam int CP_ARB_TMO_DEFAULT = 16;

  // Index width for n items, never narrower than one bit.
  function automatic int cp_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cellrv32_cpu_cp_arb_onehot.sv
// Combinational one-hot check and index encoder for the co-processor trigger vector.
module cellrv32_cpu_cp_arb_onehot
  import cellrv32_package::*;
#(
  parameter int NUM_CP = 8,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_CP-1:0] vec_i,
  output logic              onehot_o,
  output logic [SEL_W-1:0]  idx_o
);

  assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - NUM_CP'(1))) == '0);

  // Each index bit is the OR of all trigger lines whose position has that bit set;
  // the result is only meaningful when onehot_o is high.
  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_idx
    logic [NUM_CP-1:0] mask;
    for (genvar gk = 0; gk < NUM_CP; gk++) begin : g_mask
      assign mask[gk] = 1'((gk >> gi) & 1);
    end
    assign idx_o[gi] = |(vec_i & mask);
  end

endmodule

// File: rtl/cellrv32_cpu_cp_arbiter.sv
// Co-processor dispatch / result collection. Optional BUSY timeout: CELLRV32_CP_ARB_TIMEOUT_EN.
module cellrv32_cpu_cp_arbiter
  import cellrv32_package::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_CP     = 8,
  parameter int TMO_CYCLES = CP_ARB_TMO_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [NUM_CP-1:0]      trig_i,
  input  logic                   kill_i,
  output logic [NUM_CP-1:0]      cp_start_o,
  input  logic [NUM_CP*XLEN-1:0] cp_res_i,
  input  logic [NUM_CP-1:0]      cp_valid_i,
  output logic [XLEN-1:0]        res_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int SEL_W = cp_sel_width(NUM_CP);

  cp_arb_state_t    state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             trig_onehot;
  logic [SEL_W-1:0] trig_idx;
  logic [XLEN-1:0]  res_arr [NUM_CP];

  cellrv32_cpu_cp_arb_onehot #(
    .NUM_CP (NUM_CP),
    .SEL_W  (SEL_W)
  ) u_onehot (
    .vec_i    (trig_i),
    .onehot_o (trig_onehot),
    .idx_o    (trig_idx)
  );

  for (genvar gi = 0; gi < NUM_CP; gi++) begin : g_unit
    assign res_arr[gi]    = cp_res_i[gi*XLEN +: XLEN];
    assign cp_start_o[gi] = (state_q == BUSY) && (sel_q == SEL_W'(gi));
  end

`ifdef CELLRV32_CP_ARB_TIMEOUT_EN
  localparam int CNT_W = cp_sel_width(TMO_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_hit;
  assign tmo_hit = (cnt_q == CNT_W'(TMO_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    res_d   = res_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef CELLRV32_CP_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (trig_i != '0) begin
          if (trig_onehot) begin
            sel_d   = trig_idx;
            state_d = BUSY;
`ifdef CELLRV32_CP_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
            res_d  = '0;
          end
        end
      end
      BUSY: begin
`ifdef CELLRV32_CP_ARB_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        // Priority: kill, then valid, then timeout.
        if (kill_i) begin
          state_d = IDLE;
        end else if (cp_valid_i[sel_q]) begin
          state_d = CAPTURE;
        end
`ifdef CELLRV32_CP_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          res_d   = '0;
        end
`endif
      end
      CAPTURE: begin
        state_d = IDLE;
        if (!kill_i) begin
          res_d  = res_arr[sel_q];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign res_o  = res_q;
  assign done_o = done_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_cellrv32_cpu_cp_arbiter.sv
// Randomized transaction-level check of the co-processor arbiter against a timeline model.
module tb_cellrv32_cpu_cp_arbiter;

  localparam int XLEN = 32;
  localparam int NCP  = 8;
  localparam int TMO  = 16;

  logic              clk;
  logic              rstn;
  logic [NCP-1:0]    trig;
  logic              kill;
  logic [NCP-1:0]    cp_start;
  logic [NCP*XLEN-1:0] cp_res;
  logic [NCP-1:0]    cp_valid;
  logic [XLEN-1:0]   res;
  logic              done;
  logic              err;
  logic              busy;

  int n_checks = 0;
  int n_fails  = 0;
  logic [XLEN-1:0] res_model = '0;

  cellrv32_cpu_cp_arbiter #(
    .XLEN       (XLEN),
    .NUM_CP     (NCP),
    .TMO_CYCLES (TMO)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .trig_i     (trig),
    .kill_i     (kill),
    .cp_start_o (cp_start),
    .cp_res_i   (cp_res),
    .cp_valid_i (cp_valid),
    .res_o      (res),
    .done_o     (done),
    .err_o      (err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One transaction: multi=1 gives an illegal trigger mvec; otherwise unit u answers
  // in BUSY cycle lat (0 = same cycle as start) with result r; killj >= 0 asserts kill
  // in BUSY cycle killj (killj == lat+1 lands in CAPTURE).
  task automatic run_txn(input bit multi, input int u, input int lat,
                         input logic [31:0] r, input int killj, input logic [7:0] mvec);
    int endk, bs_hi, st_hi, gap;
    bit exp_done, exp_err, tmo;
    logic [31:0] res_after;
    logic [7:0] tv;
    tmo = 1'b0;
    if (multi) begin
      tv = mvec; endk = 1; bs_hi = 0; st_hi = 0;
      exp_done = 1'b1; exp_err = 1'b1; res_after = '0;
    end else begin
      tv = 8'(1 << u);
`ifdef CELLRV32_CP_ARB_TIMEOUT_EN
      tmo = (lat >= TMO) && (killj < 0 || killj > TMO - 1);
`endif
      if (tmo) begin
        bs_hi = TMO; st_hi = TMO; endk = TMO + 1;
        exp_done = 1'b1; exp_err = 1'b1; res_after = '0;
      end else if (killj >= 0) begin
        bs_hi = killj + 1; st_hi = (killj < lat) ? killj + 1 : lat + 1; endk = killj + 2;
        exp_done = 1'b0; exp_err = 1'b0; res_after = res_model;
      end else begin
        bs_hi = lat + 2; st_hi = lat + 1; endk = lat + 3;
        exp_done = 1'b1; exp_err = 1'b0; res_after = r;
      end
    end
    gap = 1 + int'($urandom % 3);
    for (int k = 0; k <= endk + gap; k++) begin
      @(negedge clk);
      chk("busy",  32'(busy),     32'(k >= 1 && k <= bs_hi));
      chk("start", 32'(cp_start), (k >= 1 && k <= st_hi) ? 32'(tv) : 32'd0);
      chk("done",  32'(done),     (k == endk) ? 32'(exp_done) : 32'd0);
      chk("err",   32'(err),      (k == endk) ? 32'(exp_err) : 32'd0);
      chk("res",   res,           (k >= endk) ? res_after : res_model);
      if (k == 0)                                         trig = tv;
      else if (k <= bs_hi && ($urandom % 4) == 0)         trig = 8'($urandom);
      else                                                trig = '0;
      kill = (killj >= 0) && (k == killj + 1);
      cp_valid = 8'($urandom);
      if (!multi) cp_valid[u] = (k == lat + 1);
      for (int i = 0; i < NCP; i++) cp_res[i*XLEN +: XLEN] = $urandom;
      if (!multi && k == lat + 2) cp_res[u*XLEN +: XLEN] = r;
    end
    res_model = res_after;
    $display("txn multi=%0d unit=%0d lat=%0d kill=%0d res=%h checks=%0d fails=%0d",
             multi, u, lat, killj, res_after, n_checks, n_fails);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, u, lat, kj, a, b;
    logic [7:0] mv;
    rstn = 1'b1; trig = '0; kill = 1'b0; cp_valid = '0; cp_res = '0;
    #1 rstn = 1'b0;
    #2;
    chk("rst_busy",  32'(busy), 0);
    chk("rst_start", 32'(cp_start), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    chk("rst_res",   res, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    run_txn(1'b0, 4, 0, 32'hDEAD_BEEF, -1, 8'h00);
    run_txn(1'b0, 0, 4, 32'h0000_0042, -1, 8'h00);
    run_txn(1'b1, 0, 0, 32'h0, -1, 8'h03);
    run_txn(1'b0, 3, 2, 32'h1234_5678, 2, 8'h00);
    run_txn(1'b0, 5, 1, 32'hCAFE_F00D, 2, 8'h00);
    run_txn(1'b0, 6, 3, 32'h0BAD_0BAD, -1, 8'h00);
    run_txn(1'b0, 7, 40, 32'h5555_AAAA, 25, 8'h00);

    // Asynchronous reset while BUSY on unit 2.
    @(negedge clk);
    trig = 8'h04; kill = 1'b0; cp_valid = '0;
    @(negedge clk);
    trig = '0;
    chk("mid_busy",  32'(busy), 1);
    chk("mid_start", 32'(cp_start), 32'h04);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy",  32'(busy), 0);
    chk("arst_start", 32'(cp_start), 0);
    chk("arst_done",  32'(done), 0);
    chk("arst_err",   32'(err), 0);
    chk("arst_res",   res, 0);
    @(negedge clk);
    rstn = 1'b1;
    res_model = '0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 0);
    $display("txn reset-mid-busy checks=%0d fails=%0d", n_checks, n_fails);

    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom % 8);
      u    = int'($urandom % NCP);
      lat  = (($urandom % 8) == 0) ? 17 + int'($urandom % 4) : int'($urandom % 7);
      kj   = -1;
      mv   = 8'h00;
      if (kind == 0) begin
        a  = int'($urandom % NCP);
        b  = (a + 1 + int'($urandom % (NCP - 1))) % NCP;
        mv = 8'($urandom);
        mv[a] = 1'b1;
        mv[b] = 1'b1;
      end else if (kind == 1) begin
        kj = int'($urandom % (lat + 2));
      end
      run_txn(kind == 0, u, lat, $urandom, kj, mv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
